// File: rtl/votacao_dia.sv
// votacao_dia: day-phase vote controller for the werewolf game.
// Serves each living player once as voter, tallies the votes and names the eliminated player.
module votacao_dia #(
    parameter int N_JOGADORES = 5,
    parameter int TIMEOUT     = 1000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   iniciar,
    input  logic [N_JOGADORES-1:0] vivos,
    input  logic                   voto_valido,
    input  logic [2:0]             voto,
    input  logic                   passa,
    output logic [2:0]             eleitor_atual,
    output logic                   aguardando_voto,
    output logic                   pronto,
    output logic [2:0]             eliminado,
    output logic                   houve_eliminacao,
    output logic [3:0]             db_estado
);

    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [3:0] {
        OCIOSO  = 4'd0,
        PROCURA = 4'd1,
        ESPERA  = 4'd2,
        APURA   = 4'd3,
        FIM     = 4'd4
    } estado_t;

    estado_t                state_r, state_s;
    logic [N_JOGADORES-1:0] vivos_r;
    logic [2:0]             contagem_r [N_JOGADORES];
    logic [TW-1:0]          timer_r;
    logic [2:0]             scan_r, max_r, idx_r;
    logic                   empate_r;

    logic [2:0]  eleitor_r, eleitor_s;
    logic        aguardando_r, aguardando_s;
    logic        pronto_r, pronto_s;
    logic [2:0]  eliminado_r, eliminado_s;
    logic        houve_r, houve_s;

    logic [7:0]  vivos_ext_s;
    logic [23:0] cont_flat_s;
    logic [2:0]  cnt_scan_s, max_s, idx_s;
    logic        empate_s;
    logic        fim_procura_s, eleitor_vivo_s, voto_ok_s, estouro_s, sai_espera_s, ultimo_scan_s;

    // Decode of the current voter, the vote qualification and the exit conditions
    always_comb begin
        vivos_ext_s    = 8'(vivos_r);
        fim_procura_s  = (eleitor_r == 3'(N_JOGADORES));
        eleitor_vivo_s = vivos_ext_s[eleitor_r];
        voto_ok_s      = voto_valido && ({5'd0, voto} < 8'(N_JOGADORES))
                         && vivos_ext_s[voto] && (voto != eleitor_r);
        estouro_s      = (timer_r == TW'(TIMEOUT - 1));
        sai_espera_s   = voto_ok_s || passa || estouro_s;
        ultimo_scan_s  = (scan_r == 3'(N_JOGADORES - 1));
    end

    // Scan step: fold the counter under scan_r into the running max / index / tie state
    always_comb begin
        cont_flat_s = 24'd0;
        for (int i = 0; i < N_JOGADORES; i++) begin
            cont_flat_s[i*3 +: 3] = contagem_r[i];
        end
        cnt_scan_s = cont_flat_s[scan_r*3 +: 3];
        max_s      = max_r;
        idx_s      = idx_r;
        empate_s   = empate_r;
        if (cnt_scan_s > max_r) begin
            max_s    = cnt_scan_s;
            idx_s    = scan_r;
            empate_s = 1'b0;
        end else if ((cnt_scan_s == max_r) && (max_r != 3'd0)) begin
            empate_s = 1'b1;
        end else begin
            empate_s = empate_r;
        end
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= OCIOSO;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            OCIOSO: begin
                if (iniciar) state_s = PROCURA;
                else         state_s = OCIOSO;
            end
            PROCURA: begin
                if (fim_procura_s)       state_s = APURA;
                else if (eleitor_vivo_s) state_s = ESPERA;
                else                     state_s = PROCURA;
            end
            ESPERA: begin
                if (sai_espera_s) state_s = PROCURA;
                else              state_s = ESPERA;
            end
            APURA: begin
                if (ultimo_scan_s) state_s = FIM;
                else               state_s = APURA;
            end
            FIM:     state_s = OCIOSO;
            default: state_s = OCIOSO;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        aguardando_s = (state_s == ESPERA);
        pronto_s     = (state_s == FIM);
        eleitor_s    = eleitor_r;
        eliminado_s  = eliminado_r;
        houve_s      = houve_r;
        case (state_r)
            OCIOSO: begin
                if (iniciar) begin
                    eleitor_s   = 3'd0;
                    eliminado_s = 3'd7;
                    houve_s     = 1'b0;
                end else begin
                    eleitor_s = eleitor_r;
                end
            end
            PROCURA: begin
                if (!fim_procura_s && !eleitor_vivo_s) eleitor_s = eleitor_r + 3'd1;
                else                                   eleitor_s = eleitor_r;
            end
            ESPERA: begin
                if (sai_espera_s) eleitor_s = eleitor_r + 3'd1;
                else              eleitor_s = eleitor_r;
            end
            APURA: begin
                // The last scan result is folded in here so the verdict lands with pronto
                if (ultimo_scan_s && (max_s != 3'd0) && !empate_s) begin
                    eliminado_s = idx_s;
                    houve_s     = 1'b1;
                end else if (ultimo_scan_s) begin
                    eliminado_s = 3'd7;
                    houve_s     = 1'b0;
                end else begin
                    eliminado_s = eliminado_r;
                end
            end
            default: eleitor_s = eleitor_r;
        endcase
    end

    // Output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            eleitor_r    <= 3'd0;
            aguardando_r <= 1'b0;
            pronto_r     <= 1'b0;
            eliminado_r  <= 3'd7;
            houve_r      <= 1'b0;
        end else begin
            eleitor_r    <= eleitor_s;
            aguardando_r <= aguardando_s;
            pronto_r     <= pronto_s;
            eliminado_r  <= eliminado_s;
            houve_r      <= houve_s;
        end
    end

    // Datapath: latched mask, tally counters, timeout timer and scan registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vivos_r  <= '0;
            timer_r  <= '0;
            scan_r   <= 3'd0;
            max_r    <= 3'd0;
            idx_r    <= 3'd0;
            empate_r <= 1'b0;
            for (int i = 0; i < N_JOGADORES; i++) contagem_r[i] <= 3'd0;
        end else begin
            case (state_r)
                OCIOSO: begin
                    if (iniciar) begin
                        vivos_r  <= vivos;
                        scan_r   <= 3'd0;
                        max_r    <= 3'd0;
                        idx_r    <= 3'd0;
                        empate_r <= 1'b0;
                        for (int i = 0; i < N_JOGADORES; i++) contagem_r[i] <= 3'd0;
                    end
                end
                PROCURA: begin
                    timer_r <= '0;
                    scan_r  <= 3'd0;
                end
                ESPERA: begin
                    timer_r <= timer_r + TW'(1);
                    for (int i = 0; i < N_JOGADORES; i++) begin
                        if (voto_ok_s && (voto == 3'(i))) contagem_r[i] <= contagem_r[i] + 3'd1;
                    end
                end
                APURA: begin
                    scan_r   <= scan_r + 3'd1;
                    max_r    <= max_s;
                    idx_r    <= idx_s;
                    empate_r <= empate_s;
                end
                default: scan_r <= scan_r;
            endcase
        end
    end

    assign eleitor_atual    = eleitor_r;
    assign aguardando_voto  = aguardando_r;
    assign pronto           = pronto_r;
    assign eliminado        = eliminado_r;
    assign houve_eliminacao = houve_r;
    assign db_estado        = state_r;

endmodule

// File: tb/tb_votacao_dia.sv
// Bench for votacao_dia: scenario tasks drive rounds, a queue holds the expected verdict
// of each round (from an independent tally model) and is popped when pronto appears.
module tb_votacao_dia;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic [4:0] vivos = 5'd0;
    logic       voto_valido = 1'b0;
    logic [2:0] voto = 3'd0;
    logic       passa = 1'b0;
    logic [2:0] eleitor_atual;
    logic       aguardando_voto;
    logic       pronto;
    logic [2:0] eliminado;
    logic       houve_eliminacao;
    logic [3:0] db_estado;

    int n_checks = 0;
    int n_fails  = 0;
    logic [3:0] fila [$];

    votacao_dia #(.N_JOGADORES(5), .TIMEOUT(8)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .vivos(vivos),
        .voto_valido(voto_valido), .voto(voto), .passa(passa),
        .eleitor_atual(eleitor_atual), .aguardando_voto(aguardando_voto),
        .pronto(pronto), .eliminado(eliminado),
        .houve_eliminacao(houve_eliminacao), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected {houve, eliminado} from the target of each voter (-1 = abstain)
    function automatic logic [3:0] esperado(input int alvo[5]);
        int cnt[5];
        int m = 0;
        int w = 7;
        int n_max = 0;
        for (int i = 0; i < 5; i++) cnt[i] = 0;
        for (int i = 0; i < 5; i++) if (alvo[i] >= 0) cnt[alvo[i]]++;
        for (int i = 0; i < 5; i++) if (cnt[i] > m) m = cnt[i];
        for (int i = 0; i < 5; i++) if (m > 0 && cnt[i] == m) begin n_max++; w = i; end
        if (m == 0 || n_max > 1) return {1'b0, 3'd7};
        return {1'b1, 3'(w)};
    endfunction

    task automatic iniciar_rodada(input logic [4:0] mask, input int alvo[5]);
        vivos = mask;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        fila.push_back(esperado(alvo));
    endtask

    task automatic espera_eleitor(input int v);
        int n = 0;
        while (!(aguardando_voto && eleitor_atual == 3'(v)) && n < 60) begin
            tick();
            n++;
        end
        n_checks++;
        if (n >= 60) begin
            n_fails++;
            $display("FAIL wait_voter: aguardando=%0b eleitor=%0d, required voter %0d in ESPERA",
                     aguardando_voto, eleitor_atual, v);
        end
    endtask

    task automatic vota(input int v, input int alvo);
        espera_eleitor(v);
        voto_valido = 1'b1;
        voto = 3'(alvo);
        tick();
        voto_valido = 1'b0;
    endtask

    task automatic abstem(input int v);
        espera_eleitor(v);
        passa = 1'b1;
        tick();
        passa = 1'b0;
    endtask

    // Waits for pronto; reports ticks spent and whether ESPERA was seen meanwhile
    task automatic espera_pronto(output int n, output logic viu_espera);
        n = 0;
        viu_espera = aguardando_voto;
        while (!pronto && n < 200) begin
            tick();
            n++;
            if (aguardando_voto) viu_espera = 1'b1;
        end
        n_checks++;
        if (!pronto) begin
            n_fails++;
            $display("FAIL wait_pronto: pronto=%0b after %0d cycles, required 1", pronto, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if ({db_estado, eleitor_atual, aguardando_voto, pronto, eliminado, houve_eliminacao}
            !== {4'd0, 3'd0, 1'b0, 1'b0, 3'd7, 1'b0}) begin
            n_fails++;
            $display("FAIL reset_state: estado=%0d eleitor=%0d aguardando=%0b pronto=%0b elim=%0d houve=%0b, required 0 0 0 0 7 0",
                     db_estado, eleitor_atual, aguardando_voto, pronto, eliminado, houve_eliminacao);
        end
    endtask

    task automatic test_vencedor();
        int alvo[5] = '{2, 2, 3, 2, 1};
        int n;
        logic viu;
        logic [3:0] exp;
        iniciar_rodada(5'b11111, alvo);
        n_checks++;
        if (db_estado !== 4'd1 || eleitor_atual !== 3'd0) begin
            n_fails++;
            $display("FAIL start_state: estado=%0d eleitor=%0d, required 1 0", db_estado, eleitor_atual);
        end
        for (int i = 0; i < 5; i++) vota(i, alvo[i]);
        espera_pronto(n, viu);
        exp = fila.pop_front();
        n_checks++;
        if ({houve_eliminacao, eliminado} !== exp) begin
            n_fails++;
            $display("FAIL winner_result: houve=%0b elim=%0d, required %0b %0d",
                     houve_eliminacao, eliminado, exp[3], exp[2:0]);
        end
        tick();
        n_checks++;
        if (pronto !== 1'b0 || db_estado !== 4'd0 || eliminado !== exp[2:0]) begin
            n_fails++;
            $display("FAIL pronto_pulse: pronto=%0b estado=%0d elim=%0d, required 0 0 %0d",
                     pronto, db_estado, eliminado, exp[2:0]);
        end
    endtask

    task automatic test_empate();
        int alvo[5] = '{1, 0, 1, 0, -1};
        int n;
        logic viu;
        logic [3:0] exp;
        iniciar_rodada(5'b01111, alvo);
        for (int i = 0; i < 4; i++) vota(i, alvo[i]);
        espera_pronto(n, viu);
        exp = fila.pop_front();
        n_checks++;
        if ({houve_eliminacao, eliminado} !== exp) begin
            n_fails++;
            $display("FAIL tie_result: houve=%0b elim=%0d, required %0b %0d",
                     houve_eliminacao, eliminado, exp[3], exp[2:0]);
        end
        n_checks++;
        if (viu !== 1'b0) begin
            n_fails++;
            $display("FAIL tie_dead_voter: aguardando seen for voter 4 = %0b, required 0", viu);
        end
        tick();
    endtask

    task automatic test_invalido_timeout();
        int alvo[5] = '{2, -1, -1, -1, 2};
        int n;
        logic viu;
        logic [3:0] exp;
        iniciar_rodada(5'b10101, alvo);
        espera_eleitor(0);
        for (int k = 0; k < 2; k++) begin
            voto_valido = 1'b1;
            voto = (k == 0) ? 3'd1 : 3'd0;
            tick();
            voto_valido = 1'b0;
            n_checks++;
            if (aguardando_voto !== 1'b1 || eleitor_atual !== 3'd0) begin
                n_fails++;
                $display("FAIL invalid_vote_%0d: aguardando=%0b eleitor=%0d, required 1 0",
                         k, aguardando_voto, eleitor_atual);
            end
        end
        vota(0, 2);
        espera_eleitor(2);
        n = 0;
        while (aguardando_voto && n < 30) begin
            n++;
            tick();
        end
        n_checks++;
        if (n != 8 || eleitor_atual !== 3'd3) begin
            n_fails++;
            $display("FAIL timeout_len: espera cycles=%0d eleitor=%0d, required 8 3", n, eleitor_atual);
        end
        vota(4, 2);
        espera_pronto(n, viu);
        exp = fila.pop_front();
        n_checks++;
        if ({houve_eliminacao, eliminado} !== exp) begin
            n_fails++;
            $display("FAIL timeout_result: houve=%0b elim=%0d, required %0b %0d",
                     houve_eliminacao, eliminado, exp[3], exp[2:0]);
        end
        tick();
    endtask

    task automatic test_sem_vivos();
        int alvo[5] = '{-1, -1, -1, -1, -1};
        int n;
        logic viu;
        logic [3:0] exp;
        iniciar_rodada(5'b00000, alvo);
        espera_pronto(n, viu);
        exp = fila.pop_front();
        n_checks++;
        if (n != 11) begin
            n_fails++;
            $display("FAIL empty_latency: pronto at k+%0d, required k+12", n + 1);
        end
        n_checks++;
        if ({houve_eliminacao, eliminado} !== exp || viu !== 1'b0) begin
            n_fails++;
            $display("FAIL empty_result: houve=%0b elim=%0d aguardando_seen=%0b, required %0b %0d 0",
                     houve_eliminacao, eliminado, viu, exp[3], exp[2:0]);
        end
        tick();
    endtask

    task automatic test_simultaneo();
        int alvo[5] = '{3, 3, -1, 0, -1};
        int n;
        logic viu;
        logic [3:0] exp;
        iniciar_rodada(5'b11111, alvo);
        espera_eleitor(0);
        voto_valido = 1'b1;
        voto = 3'd3;
        passa = 1'b1;
        tick();
        voto_valido = 1'b0;
        passa = 1'b0;
        espera_eleitor(1);
        iniciar = 1'b1;
        vivos = 5'b00000;
        tick();
        iniciar = 1'b0;
        n_checks++;
        if (db_estado !== 4'd2 || eleitor_atual !== 3'd1) begin
            n_fails++;
            $display("FAIL iniciar_ignored: estado=%0d eleitor=%0d, required 2 1", db_estado, eleitor_atual);
        end
        vota(1, 3);
        abstem(2);
        vota(3, 0);
        abstem(4);
        espera_pronto(n, viu);
        exp = fila.pop_front();
        n_checks++;
        if ({houve_eliminacao, eliminado} !== exp) begin
            n_fails++;
            $display("FAIL simultaneous_result: houve=%0b elim=%0d, required %0b %0d",
                     houve_eliminacao, eliminado, exp[3], exp[2:0]);
        end
        tick();
    endtask

    task automatic test_reset_meio();
        int velho[5] = '{1, 1, -1, -1, -1};
        int novo[5]  = '{4, 4, -1, -1, -1};
        int n;
        logic viu;
        logic [3:0] exp;
        iniciar_rodada(5'b11111, velho);
        vota(0, 1);
        vota(1, 1);
        espera_eleitor(2);
        reset = 1'b1;
        #2;
        n_checks++;
        if ({db_estado, eleitor_atual, eliminado, pronto, aguardando_voto}
            !== {4'd0, 3'd0, 3'd7, 1'b0, 1'b0}) begin
            n_fails++;
            $display("FAIL mid_reset: estado=%0d eleitor=%0d elim=%0d pronto=%0b aguardando=%0b, required 0 0 7 0 0",
                     db_estado, eleitor_atual, eliminado, pronto, aguardando_voto);
        end
        reset = 1'b0;
        void'(fila.pop_back());
        tick();
        iniciar_rodada(5'b11111, novo);
        vota(0, 4);
        vota(1, 4);
        abstem(2);
        abstem(3);
        abstem(4);
        espera_pronto(n, viu);
        exp = fila.pop_front();
        n_checks++;
        if ({houve_eliminacao, eliminado} !== exp) begin
            n_fails++;
            $display("FAIL after_reset_result: houve=%0b elim=%0d, required %0b %0d",
                     houve_eliminacao, eliminado, exp[3], exp[2:0]);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_vencedor();
        test_empate();
        test_invalido_timeout();
        test_sem_vivos();
        test_simultaneo();
        test_reset_meio();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
